// File: rtl/lcd_pkg.sv
// Shared encodings for the LCD test-pattern writer: bar colours, pattern select and FSM states.
package lcd_pkg;

    localparam logic [15:0] RGB_WHITE   = 16'hFFFF;
    localparam logic [15:0] RGB_YELLOW  = 16'hFFE0;
    localparam logic [15:0] RGB_CYAN    = 16'h07FF;
    localparam logic [15:0] RGB_GREEN   = 16'h07E0;
    localparam logic [15:0] RGB_MAGENTA = 16'hF81F;
    localparam logic [15:0] RGB_RED     = 16'hF800;
    localparam logic [15:0] RGB_BLUE    = 16'h001F;
    localparam logic [15:0] RGB_BLACK   = 16'h0000;

    typedef enum logic [1:0] {
        PAT_BARS  = 2'd0,
        PAT_GRAD  = 2'd1,
        PAT_CHK   = 2'd2,
        PAT_SOLID = 2'd3
    } pat_sel_t;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_FILL     = 2'd1,
        ST_WAIT_SOF = 2'd2
    } state_t;

    function automatic logic [15:0] bar_color(input logic [2:0] idx);
        case (idx)
            3'd0:    return RGB_WHITE;
            3'd1:    return RGB_YELLOW;
            3'd2:    return RGB_CYAN;
            3'd3:    return RGB_GREEN;
            3'd4:    return RGB_MAGENTA;
            3'd5:    return RGB_RED;
            3'd6:    return RGB_BLUE;
            default: return RGB_BLACK;
        endcase
    endfunction

endpackage

// File: rtl/lcd_pattern_pixel.sv
// RGB565 test-pattern generator: (x, y, bar index, select) -> pixel.
// Purely combinational; no backpressure of its own.
module lcd_pattern_pixel
    import lcd_pkg::*;
#(
    parameter int CHK_LOG2 = 5
) (
    input  logic [7:0]  x,
    input  logic [7:0]  y,
    input  logic [2:0]  bar,
    input  logic [1:0]  sel,
    output logic [15:0] pixel
);

    logic [4:0] grad_b;

    // Only the low 8 bits of x and y matter: the gradient wraps every 256 pixels.
    assign grad_b = 5'((x + y) >> 3);

    always_comb begin
        pixel = RGB_WHITE;
        case (sel)
            PAT_BARS:  pixel = bar_color(bar);
            PAT_GRAD:  pixel = {x[7:3], y[7:2], grad_b};
            PAT_CHK:   pixel = (x[CHK_LOG2] ^ y[CHK_LOG2]) ? RGB_WHITE : RGB_BLACK;
            PAT_SOLID: pixel = RGB_WHITE;
            default:   pixel = RGB_WHITE;
        endcase
    end

endmodule

// File: rtl/lcd_pattern_writer.sv
// Streams one RGB565 test frame per VSYNC fall into the display FIFO, high byte first.
// First write 3 cycles after VSYNC falls, then 1 byte/cycle; FIFO_FULL stalls writes with no loss.
module lcd_pattern_writer
    import lcd_pkg::*;
#(
    parameter int H_ACTIVE = 800,
    parameter int V_ACTIVE = 480,
    parameter int BAR_W    = 100,
    parameter int CHK_LOG2 = 5
) (
    input  logic       CLK,
    input  logic       nRST,
    input  logic       VSYNC,
    input  logic [1:0] PAT_SEL,
    input  logic       FIFO_FULL,
    output logic       FIFO_WE,
    output logic [7:0] FIFO_DI,
    output logic       FRAME_DONE,
    output logic       FRAME_ERR,
    output logic       BUSY
);

    localparam int XW = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
    localparam int YW = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;
    localparam int BW = (BAR_W > 1) ? $clog2(BAR_W) : 1;
    localparam logic [XW-1:0] X_LAST  = XW'(H_ACTIVE - 1);
    localparam logic [YW-1:0] Y_LAST  = YW'(V_ACTIVE - 1);
    localparam logic [BW-1:0] BP_LAST = BW'(BAR_W - 1);

    logic          sync1, sync2, sync3, armed, sof;
    logic [1:0]    sync_vld;
    state_t        state, state_nxt;
    pat_sel_t      sel;
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic [BW-1:0] bar_pos;
    logic [2:0]    bar_idx;
    logic          phase, last_write;
    logic [15:0]   pixel;

    // Flops reset to 1, so a VSYNC already low at reset release must not look like a
    // falling edge: arm only after a genuinely sampled high level has reached sync2.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            sync1    <= 1'b1;
            sync2    <= 1'b1;
            sync3    <= 1'b1;
            sync_vld <= 2'b00;
            armed    <= 1'b0;
        end else begin
            sync1    <= VSYNC;
            sync2    <= sync1;
            sync3    <= sync2;
            sync_vld <= {sync_vld[0], 1'b1};
            if (sync_vld[1] && sync2) begin
                armed <= 1'b1;
            end
        end
    end

    assign sof        = armed && !sync2 && sync3;
    assign last_write = FIFO_WE && phase && (x == X_LAST) && (y == Y_LAST);

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // A new frame start always wins, including over the final write of the current frame.
    always_comb begin
        state_nxt = state;
        if (sof) begin
            state_nxt = ST_FILL;
        end else if (state == ST_FILL && last_write) begin
            state_nxt = ST_WAIT_SOF;
        end
    end

    always_comb begin
        BUSY    = (state == ST_FILL);
        FIFO_WE = BUSY && !FIFO_FULL;
        FIFO_DI = 8'h00;
        if (BUSY) begin
            FIFO_DI = phase ? pixel[7:0] : pixel[15:8];
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            x       <= '0;
            y       <= '0;
            phase   <= 1'b0;
            bar_idx <= '0;
            bar_pos <= '0;
            sel     <= PAT_BARS;
        end else if (sof) begin
            x       <= '0;
            y       <= '0;
            phase   <= 1'b0;
            bar_idx <= '0;
            bar_pos <= '0;
            sel     <= pat_sel_t'(PAT_SEL);
        end else if (FIFO_WE) begin
            phase <= ~phase;
            if (phase) begin
                if (x == X_LAST) begin
                    x       <= '0;
                    bar_idx <= '0;
                    bar_pos <= '0;
                    y       <= (y == Y_LAST) ? '0 : y + 1'b1;
                end else begin
                    x <= x + 1'b1;
                    if (bar_pos == BP_LAST) begin
                        bar_pos <= '0;
                        bar_idx <= bar_idx + 1'b1;
                    end else begin
                        bar_pos <= bar_pos + 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            FRAME_DONE <= 1'b0;
            FRAME_ERR  <= 1'b0;
        end else begin
            FRAME_DONE <= last_write;
            FRAME_ERR  <= sof && (state == ST_FILL) && !last_write;
        end
    end

    lcd_pattern_pixel #(
        .CHK_LOG2 (CHK_LOG2)
    ) u_pixel (
        .x     (8'(x)),
        .y     (8'(y)),
        .bar   (bar_idx),
        .sel   (sel),
        .pixel (pixel)
    );

endmodule

// File: tb/tb_lcd_pattern_writer.sv
// Randomized bench for lcd_pattern_writer on a 16x4 frame, checked against a frame-level byte model.
module tb_lcd_pattern_writer;

    localparam int H = 16;
    localparam int V = 4;
    localparam int BARW = 2;
    localparam int CHK = 1;
    localparam int FRAME_BYTES = 2 * H * V;

    logic       clk, nrst, vsync, fifo_full;
    logic [1:0] pat_sel;
    logic       fifo_we, frame_done, frame_err, busy;
    logic [7:0] fifo_di;

    lcd_pattern_writer #(
        .H_ACTIVE (H),
        .V_ACTIVE (V),
        .BAR_W    (BARW),
        .CHK_LOG2 (CHK)
    ) dut (
        .CLK        (clk),
        .nRST       (nrst),
        .VSYNC      (vsync),
        .PAT_SEL    (pat_sel),
        .FIFO_FULL  (fifo_full),
        .FIFO_WE    (fifo_we),
        .FIFO_DI    (fifo_di),
        .FRAME_DONE (frame_done),
        .FRAME_ERR  (frame_err),
        .BUSY       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [15:0] bar_tab [8] = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
                                 16'hF81F, 16'hF800, 16'h001F, 16'h0000};
    logic [7:0]  first_bytes [6] = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hE0};

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int sof_at = -100;
    int fall_cyc = -100;
    int first_we_cyc = -1;
    int done_cnt = 0;
    int err_cnt = 0;
    int fill_cyc = 0;
    int full_cyc = 0;

    logic       m_active = 1'b0;
    logic       m_done = 1'b0;
    logic       m_err = 1'b0;
    logic [1:0] m_sel = 2'd0;
    int         m_idx = 0;

    logic [7:0] stream [$];
    logic [7:0] stream_a [$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [7:0] exp_byte(input logic [1:0] sel, input int idx);
        int p, x, y, r, g, b;
        logic [15:0] px;
        p = idx / 2;
        x = p % H;
        y = p / H;
        case (sel)
            2'd0: px = bar_tab[x / BARW];
            2'd1: begin
                r  = (x >> 3) & 31;
                g  = (y >> 2) & 63;
                b  = ((x + y) >> 3) & 31;
                px = 16'((r << 11) | (g << 5) | b);
            end
            2'd2: px = (((x >> CHK) ^ (y >> CHK)) & 1) != 0 ? 16'hFFFF : 16'h0000;
            default: px = 16'hFFFF;
        endcase
        return (idx % 2 == 0) ? px[15:8] : px[7:0];
    endfunction

    task automatic model_reset();
        m_active = 1'b0;
        m_idx    = 0;
        m_done   = 1'b0;
        m_err    = 1'b0;
        sof_at   = -100;
        fill_cyc = 0;
        full_cyc = 0;
    endtask

    // Checks one cycle mid-cycle, then advances the model across the next rising edge.
    task automatic step();
        logic exp_we, last, sof_now;
        @(negedge clk);
        cyc++;
        sof_now = (cyc == sof_at);
        exp_we  = m_active && !fifo_full;
        check_eq("fifo_we", fifo_we, exp_we);
        if (exp_we) check_eq("fifo_di", fifo_di, exp_byte(m_sel, m_idx));
        check_eq("frame_done", frame_done, m_done);
        check_eq("frame_err", frame_err, m_err);
        check_eq("busy", busy, m_active);
        if (fifo_we) begin
            stream.push_back(fifo_di);
            if (first_we_cyc < 0) first_we_cyc = cyc;
        end
        if (frame_done) done_cnt++;
        if (frame_err) err_cnt++;
        if (busy) begin
            fill_cyc++;
            if (fifo_full) full_cyc++;
        end
        last   = exp_we && (m_idx == FRAME_BYTES - 1);
        m_done = last;
        m_err  = sof_now && m_active && !last;
        if (last) begin
            check_eq("fill_len", fill_cyc, FRAME_BYTES + full_cyc);
            fill_cyc = 0;
            full_cyc = 0;
            m_active = 1'b0;
            m_idx    = 0;
        end else if (exp_we) begin
            m_idx++;
        end
        if (sof_now) begin
            m_active = 1'b1;
            m_idx    = 0;
            m_sel    = pat_sel;
            fill_cyc = 0;
            full_cyc = 0;
        end
        @(posedge clk);
        #1;
    endtask

    // mode 0: never full, 1: full one cycle in three, 2: full ~30% at random.
    // sel_mid < 0 randomizes PAT_SEL every cycle once the frame is running.
    task automatic drive(input int mode, input int sel_mid);
        case (mode)
            0:       fifo_full = 1'b0;
            1:       fifo_full = (cyc % 3 == 0);
            default: fifo_full = ($urandom_range(99) < 30);
        endcase
        if (m_active) pat_sel = (sel_mid < 0) ? 2'($urandom_range(3)) : 2'(sel_mid);
        if (!vsync && cyc >= fall_cyc + 3) vsync = 1'b1;
    endtask

    task automatic vsync_fall();
        vsync        = 1'b0;
        fall_cyc     = cyc + 1;
        sof_at       = fall_cyc + 2;
        first_we_cyc = -1;
    endtask

    task automatic run_until_idle(input int mode, input int sel_mid);
        int budget;
        budget = 3000;
        do begin
            step();
            drive(mode, sel_mid);
            budget--;
        end while ((m_active || !vsync || sof_at >= cyc) && budget > 0);
        if (budget == 0) check_eq("idle_timeout", 0, 1);
        repeat (3) begin
            step();
            drive(mode, sel_mid);
        end
    endtask

    task automatic run_to_idx(input int mode, input int idx);
        int budget;
        budget = 1000;
        while (!(m_active && m_idx == idx) && budget > 0) begin
            step();
            drive(mode, -1);
            budget--;
        end
        if (budget == 0) check_eq("idx_timeout", 0, 1);
    endtask

    task automatic run_frame(input int mode, input int sel0, input int sel_mid);
        pat_sel = 2'(sel0);
        vsync_fall();
        run_until_idle(mode, sel_mid);
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        nrst = 1'b0;
        vsync = 1'b1;
        fifo_full = 1'b0;
        pat_sel = 2'd0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_we", fifo_we, 0);
        check_eq("rst_di", fifo_di, 0);
        check_eq("rst_done", frame_done, 0);
        check_eq("rst_err", frame_err, 0);
        check_eq("rst_busy", busy, 0);
        nrst = 1'b1;
        idle(5);

        // Unthrottled bars frame: latency, opening bytes, full length.
        stream.delete();
        run_frame(0, 0, 0);
        check_eq("first_we_lat", first_we_cyc - fall_cyc, 3);
        check_eq("len_a", stream.size(), FRAME_BYTES);
        for (int i = 0; i < 6; i++) check_eq("first_bytes", stream[i], first_bytes[i]);
        stream_a = stream;

        // Same frame throttled one cycle in three must yield an identical stream.
        stream.delete();
        run_frame(1, 0, 0);
        check_eq("len_b", stream.size(), FRAME_BYTES);
        for (int i = 0; i < FRAME_BYTES && i < stream.size(); i++)
            check_eq("stream_b", stream[i], stream_a[i]);

        // Checkerboard with PAT_SEL moved to solid mid-frame, then random frames.
        run_frame(2, 2, 3);
        for (int i = 0; i < 5; i++) run_frame(2, i % 4, -1);

        // Overrun: a new frame start after 40 bytes.
        done_cnt = 0;
        err_cnt  = 0;
        pat_sel  = 2'd1;
        vsync_fall();
        run_to_idx(2, 40);
        pat_sel = 2'd0;
        vsync_fall();
        run_until_idle(2, -1);
        check_eq("ovr_err_cnt", err_cnt, 1);
        check_eq("ovr_done_cnt", done_cnt, 1);

        // Frame start coincident with the final write.
        done_cnt = 0;
        err_cnt  = 0;
        pat_sel  = 2'd0;
        vsync_fall();
        run_to_idx(0, 125);
        pat_sel = 2'd2;
        vsync_fall();
        run_until_idle(0, -1);
        check_eq("coin_err_cnt", err_cnt, 0);
        check_eq("coin_done_cnt", done_cnt, 2);

        // Reset mid-frame after 20 bytes.
        pat_sel = 2'd2;
        vsync_fall();
        run_to_idx(2, 20);
        nrst = 1'b0;
        #1;
        check_eq("mid_rst_we", fifo_we, 0);
        check_eq("mid_rst_busy", busy, 0);
        check_eq("mid_rst_di", fifo_di, 0);
        check_eq("mid_rst_done", frame_done, 0);
        model_reset();
        fifo_full = 1'b0;
        vsync = 1'b1;
        idle(2);
        nrst = 1'b1;
        idle(6);
        stream.delete();
        run_frame(2, 0, -1);
        check_eq("post_rst_len", stream.size(), FRAME_BYTES);
        check_eq("post_rst_b0", stream[0], 8'hFF);

        // VSYNC already low at reset release must not start a frame.
        vsync = 1'b0;
        nrst  = 1'b0;
        model_reset();
        idle(2);
        nrst = 1'b1;
        stream.delete();
        idle(10);
        check_eq("low_rel_writes", stream.size(), 0);
        vsync = 1'b1;
        idle(5);
        run_frame(2, 1, -1);
        check_eq("low_rel_len", stream.size(), FRAME_BYTES);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
